// File: rtl/rv32_mod_data_responder.sv
// Word-addressed data responder with byte lanes, programmable wait states
// and error response for misses and unsupported byte-enable patterns.
module rv32_mod_data_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h10000000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  LAT  = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [AW-1:0]   idx_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic            wr_q;
  logic            bad_q;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [31:0]     off;
  logic            hit;
  logic            be_ok;
  logic            bad_in;
  logic [AW-1:0]   idx_in;
  logic            in_idle;
  logic [AW-1:0]   cur_idx;
  logic [3:0]      cur_be;
  logic [31:0]     cur_wdata;
  logic            cur_wr;
  logic            cur_bad;
  logic            go_resp;
  logic            we;

  // unsigned wrap makes addresses below the base fall out of range too
  assign off    = addr - BASE_ADDR;
  assign hit    = off < SPAN;
  assign idx_in = off[AW+1:2];

  always_comb begin
    be_ok = 1'b0;
    unique case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
      default:                   be_ok = 1'b0;
    endcase
  end

  assign bad_in = !hit || !be_ok;

  // zero-latency responses complete on the accepting edge itself
  assign in_idle   = (state == IDLE);
  assign cur_idx   = in_idle ? idx_in : idx_q;
  assign cur_be    = in_idle ? be     : be_q;
  assign cur_wdata = in_idle ? wdata  : wdata_q;
  assign cur_wr    = in_idle ? wr     : wr_q;
  assign cur_bad   = in_idle ? bad_in : bad_q;

  assign go_resp = req && ((in_idle && LATENCY == 0) ||
                           (state == WAIT && cnt == 4'd1));
  assign we      = go_resp && cur_wr && !cur_bad;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      ack   <= go_resp && !cur_bad;
      err   <= go_resp && cur_bad;
      rdata <= (go_resp && !cur_bad && !cur_wr) ? mem[cur_idx] : '0;
      unique case (state)
        IDLE: begin
          if (req) begin
            idx_q   <= idx_in;
            be_q    <= be;
            wdata_q <= wdata;
            wr_q    <= wr;
            bad_q   <= bad_in;
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= LAT;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == 4'd1) begin
            state <= RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mod_data_responder.sv
// Bench for rv32_mod_data_responder: a zero-latency and a three-wait-state
// instance checked every cycle against a transaction-level memory model.
module tb_rv32_mod_data_responder;

  localparam logic [31:0] BASE = 32'h10000000;
  localparam int          D    = 64;

  typedef struct {
    int          cyc;
    bit          ok;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_s   [2];
  logic        wr_s    [2];
  logic [3:0]  be_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic        ack_s   [2];
  logic        err_s   [2];
  logic [31:0] rdata_s [2];

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  bit          en = 1'b0;
  int          ack_cnt [2] = '{0, 0};
  int          err_cnt [2] = '{0, 0};
  logic [31:0] last_rd [2];
  logic [31:0] mem_m   [2][D];
  resp_t       q0 [$];
  resp_t       q1 [$];

  rv32_mod_data_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(D), .LATENCY(0)) u0 (
    .clk(clk), .reset(reset), .req(req_s[0]), .wr(wr_s[0]), .be(be_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]), .ack(ack_s[0]), .err(err_s[0]),
    .rdata(rdata_s[0]));

  rv32_mod_data_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(D), .LATENCY(3)) u1 (
    .clk(clk), .reset(reset), .req(req_s[1]), .wr(wr_s[1]), .be(be_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]), .ack(ack_s[1]), .err(err_s[1]),
    .rdata(rdata_s[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Outcome of one transaction from the address map and lane rules.
  task automatic model(input int i, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d,
                       output bit ok, output logic [31:0] rd);
    longint unsigned a64 = 64'(a);
    longint unsigned lo  = 64'(BASE);
    bit legal;
    bit hit;
    int idx;
    legal = (b == 4'b0001) || (b == 4'b0010) || (b == 4'b0100) ||
            (b == 4'b1000) || (b == 4'b0011) || (b == 4'b1100) ||
            (b == 4'b1111);
    hit = (a64 >= lo) && (a64 < lo + 4 * D);
    ok  = legal && hit;
    rd  = '0;
    if (ok) begin
      idx = int'((a64 - lo) / 4);
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (b[k]) mem_m[i][idx][8*k +: 8] = d[8*k +: 8];
      end else begin
        rd = mem_m[i][idx];
      end
    end
  endtask

  task automatic push(input int i, input resp_t r);
    if (i == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  task automatic drive(input int i, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    req_s[i] = 1'b1; wr_s[i] = w; be_s[i] = b; addr_s[i] = a; wdata_s[i] = d;
  endtask

  // Called right after a falling edge while the instance is idle.
  task automatic do_txn(input int i, input bit w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d);
    resp_t r;
    bit ok;
    logic [31:0] rd;
    model(i, w, b, a, d, ok, rd);
    drive(i, w, b, a, d);
    r.cyc  = cyc + 1 + lat(i);
    r.ok   = ok;
    r.data = (ok && !w) ? rd : 32'h0;
    push(i, r);
    repeat (lat(i) + 1) @(negedge clk);
    req_s[i] = 1'b0;
    @(negedge clk);
  endtask

  // Read with req held high across n back-to-back transactions.
  task automatic do_burst(input int i, input logic [31:0] a, input int n);
    resp_t r;
    bit ok;
    logic [31:0] rd;
    model(i, 1'b0, 4'hF, a, 32'h0, ok, rd);
    drive(i, 1'b0, 4'hF, a, 32'h0);
    for (int k = 0; k < n; k++) begin
      r.cyc  = cyc + 1 + lat(i) + k * (lat(i) + 2);
      r.ok   = ok;
      r.data = ok ? rd : 32'h0;
      push(i, r);
    end
    repeat (1 + lat(i) + (n - 1) * (lat(i) + 2)) @(negedge clk);
    req_s[i] = 1'b0;
    @(negedge clk);
  endtask

  task automatic cmp_one(input int i, input bit due, input resp_t r);
    check($sformatf("ack%0d", i), 32'(ack_s[i]), 32'(due && r.ok));
    check($sformatf("err%0d", i), 32'(err_s[i]), 32'(due && !r.ok));
    check($sformatf("rdata%0d", i), rdata_s[i], due ? r.data : 32'h0);
  endtask

  always @(negedge clk) begin
    resp_t r0;
    resp_t r1;
    bit d0;
    bit d1;
    if (en) begin
      d0 = 1'b0;
      d1 = 1'b0;
      r0 = '{0, 1'b0, 32'h0};
      r1 = '{0, 1'b0, 32'h0};
      if (q0.size() > 0 && q0[0].cyc == cyc) begin r0 = q0.pop_front(); d0 = 1'b1; end
      if (q1.size() > 0 && q1[0].cyc == cyc) begin r1 = q1.pop_front(); d1 = 1'b1; end
      cmp_one(0, d0, r0);
      cmp_one(1, d1, r1);
      for (int i = 0; i < 2; i++) begin
        if (ack_s[i] === 1'b1) begin ack_cnt[i]++; last_rd[i] = rdata_s[i]; end
        if (err_s[i] === 1'b1) err_cnt[i]++;
      end
    end
  end

  int a0;
  int e0;
  int a1;
  int e1;
  localparam logic [31:0] LAST = BASE + 32'(4 * (D - 1));

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_s[i] = 1'b0; wr_s[i] = 1'b0; be_s[i] = 4'h0;
      addr_s[i] = 32'h0; wdata_s[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("rst_ack", 32'(ack_s[i]), 32'h0);
      check("rst_err", 32'(err_s[i]), 32'h0);
      check("rst_rdata", rdata_s[i], 32'h0);
    end
    @(negedge clk);

    // first request presented together with reset release
    reset = 1'b1;
    do_txn(0, 1'b1, 4'hF, 32'h10000004, 32'hDEADBEEF);
    check("wr_first_ack", 32'(ack_cnt[0]), 32'd1);
    do_txn(0, 1'b0, 4'hF, 32'h10000004, 32'h0);
    check("rd_deadbeef", last_rd[0], 32'hDEADBEEF);
    do_txn(0, 1'b1, 4'b0100, 32'h10000006, 32'h00AA0000);
    do_txn(0, 1'b0, 4'b0001, 32'h10000004, 32'h0);
    check("rd_byte_lane", last_rd[0], 32'hDEAABEEF);

    e0 = err_cnt[0];
    a0 = ack_cnt[0];
    do_txn(0, 1'b0, 4'hF, 32'h0FFFFFFC, 32'h0);
    do_txn(0, 1'b0, 4'hF, BASE + 32'(4 * D), 32'h0);
    do_txn(0, 1'b1, 4'b0101, 32'h10000004, 32'h11111111);
    do_txn(0, 1'b1, 4'b0000, 32'h10000004, 32'h22222222);
    check("err_count", 32'(err_cnt[0] - e0), 32'd4);
    check("err_no_ack", 32'(ack_cnt[0] - a0), 32'd0);
    do_txn(0, 1'b0, 4'hF, 32'h10000004, 32'h0);
    check("err_mem_kept", last_rd[0], 32'hDEAABEEF);

    do_txn(0, 1'b1, 4'b0011, 32'h10000008, 32'h0000CAFE);
    do_txn(0, 1'b1, 4'b1100, 32'h1000000A, 32'hBABE0000);
    do_txn(0, 1'b0, 4'b1000, 32'h10000008, 32'h0);
    check("rd_halves", last_rd[0], 32'hBABECAFE);

    a0 = ack_cnt[0];
    do_burst(0, 32'h10000008, 3);
    check("burst0_acks", 32'(ack_cnt[0] - a0), 32'd3);

    do_txn(1, 1'b1, 4'hF, LAST, 32'h55AA55AA);
    do_txn(1, 1'b0, 4'hF, LAST, 32'h0);
    check("lat3_last_word", last_rd[1], 32'h55AA55AA);

    // abort: req withdrawn after two wait cycles
    a1 = ack_cnt[1];
    e1 = err_cnt[1];
    drive(1, 1'b1, 4'hF, LAST, 32'hFFFFFFFF);
    repeat (2) @(negedge clk);
    req_s[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_ack", 32'(ack_cnt[1] - a1), 32'd0);
    check("abort_no_err", 32'(err_cnt[1] - e1), 32'd0);
    do_txn(1, 1'b0, 4'hF, LAST, 32'h0);
    check("abort_mem_kept", last_rd[1], 32'h55AA55AA);

    a1 = ack_cnt[1];
    do_burst(1, LAST, 3);
    check("burst1_acks", 32'(ack_cnt[1] - a1), 32'd3);

    do_txn(1, 1'b1, 4'hF, BASE + 32'h20, 32'h12345678);
    drive(1, 1'b1, 4'hF, BASE + 32'h20, 32'hFFFFFFFF);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_ack", 32'(ack_s[1]), 32'h0);
    check("rst_mid_err", 32'(err_s[1]), 32'h0);
    check("rst_mid_rdata", rdata_s[1], 32'h0);
    req_s[1] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    do_txn(1, 1'b0, 4'hF, BASE + 32'h20, 32'h0);
    check("rst_mem_kept", last_rd[1], 32'h12345678);

    repeat (6) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
